// File: rtl/uvma_mapu_b_proto_chkr.sv
// Protocol checker for the Matrix APU Block valid/ready stream. Each channel is
// checked for handshake stability, matrix framing and stall timeouts.
module uvma_mapu_b_proto_chkr #(
  parameter int NUM_CH        = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int MATRIX_BEATS  = 9,
  parameter int TIMEOUT       = 256,
  parameter int ERR_CNT_WIDTH = 8,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         clr,
  input  logic [NUM_CH-1:0]            ch_vld,
  input  logic [NUM_CH-1:0]            ch_rdy,
  input  logic [NUM_CH-1:0]            ch_eom,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic [NUM_CH*4-1:0]          err_pulse,
  output logic [NUM_CH*4-1:0]          err_sticky,
  output logic                         err_any,
  output logic [ERR_CNT_WIDTH-1:0]     err_cnt,
  output logic                         first_vld,
  output logic [CH_W-1:0]              first_ch,
  output logic [1:0]                   first_code
);

  localparam int NUM_ERR = NUM_CH * 4;
  localparam int BEAT_W  = (MATRIX_BEATS > 1) ? $clog2(MATRIX_BEATS) : 1;
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam int POP_W   = $clog2(NUM_ERR + 1);
  localparam int SUM_W   = ((ERR_CNT_WIDTH > POP_W) ? ERR_CNT_WIDTH : POP_W) + 1;

  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(MATRIX_BEATS - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);
  localparam logic [STALL_W-1:0] STALL_PRE = STALL_W'(TIMEOUT - 1);
  localparam logic [SUM_W-1:0]   CNT_MAX   = SUM_W'({ERR_CNT_WIDTH{1'b1}});

  localparam int E_STAB = 0;
  localparam int E_DROP = 1;
  localparam int E_EOM  = 2;
  localparam int E_TMO  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  state_e                  r_state     [NUM_CH];
  state_e                  w_state_nxt [NUM_CH];
  logic [DATA_WIDTH-1:0]   r_cap_data  [NUM_CH];
  logic [NUM_CH-1:0]       r_cap_eom;
  logic [BEAT_W-1:0]       r_beat      [NUM_CH];
  logic [BEAT_W-1:0]       w_beat_nxt  [NUM_CH];
  logic [STALL_W-1:0]      r_stall     [NUM_CH];
  logic [STALL_W-1:0]      w_stall_nxt [NUM_CH];
  logic [NUM_CH-1:0]       r_tmo_hit;
  logic [NUM_CH-1:0]       w_tmo_hit_nxt;
  logic [NUM_CH-1:0]       w_cap_ld;
  logic [NUM_CH-1:0]       w_hs;
  logic [NUM_CH-1:0]       w_stall;
  logic [NUM_ERR-1:0]      w_viol;

  logic [NUM_ERR-1:0]      r_pulse;
  logic [NUM_ERR-1:0]      r_sticky;
  logic [ERR_CNT_WIDTH-1:0] r_cnt;
  logic                    r_first_vld;
  logic [CH_W-1:0]         r_first_ch;
  logic [1:0]              r_first_code;

  logic [POP_W-1:0]        w_pop;
  logic [ERR_CNT_WIDTH-1:0] w_cnt_base;
  logic [SUM_W-1:0]        w_sum;
  logic [ERR_CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CH_W-1:0]         w_first_ch;
  logic [1:0]              w_first_code;

  assign w_hs    = ch_vld & ch_rdy;
  assign w_stall = ch_vld & ~ch_rdy;

  // NOTE: combinational processes use blocking assignments and give every
  // output a default first, so no path can leave a value unassigned (no latch).
  always_comb begin
    w_viol        = '0;
    w_cap_ld      = '0;
    w_tmo_hit_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_beat_nxt[i]  = r_beat[i];
      w_stall_nxt[i] = r_stall[i];
      if (!enable) begin
        // Beat position survives a disable so a matrix can resume mid-way.
        w_state_nxt[i] = ST_IDLE;
        w_stall_nxt[i] = '0;
      end else begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_stall[i]) begin
              w_state_nxt[i] = ST_PEND;
              w_cap_ld[i]    = 1'b1;
            end
          end
          ST_PEND: begin
            if (!ch_vld[i]) begin
              w_viol[i*4 + E_DROP] = 1'b1;
              w_state_nxt[i]       = ST_IDLE;
            end else begin
              if ((ch_data[i*DATA_WIDTH +: DATA_WIDTH] != r_cap_data[i]) ||
                  (ch_eom[i] != r_cap_eom[i])) begin
                w_viol[i*4 + E_STAB] = 1'b1;
              end
              if (ch_rdy[i]) begin
                w_state_nxt[i] = ST_IDLE;
              end
            end
          end
          default: w_state_nxt[i] = ST_IDLE;
        endcase

        if (w_hs[i]) begin
          if (ch_eom[i] != (r_beat[i] == LAST_BEAT)) begin
            w_viol[i*4 + E_EOM] = 1'b1;
          end
          w_beat_nxt[i] = (ch_eom[i] || (r_beat[i] == LAST_BEAT)) ? '0
                                                                  : r_beat[i] + BEAT_W'(1);
        end

        // The hit flag marks the cycle the stall count has just reached TIMEOUT.
        if (w_stall[i]) begin
          if (r_stall[i] != STALL_MAX) begin
            w_stall_nxt[i]   = r_stall[i] + STALL_W'(1);
            w_tmo_hit_nxt[i] = (r_stall[i] == STALL_PRE);
          end
        end else begin
          w_stall_nxt[i] = '0;
        end
        w_viol[i*4 + E_TMO] = r_tmo_hit[i];
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_IDLE;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
      end
    end
  end

  // NOTE: the capture registers are reset like everything else; the checker
  // must come out of reset with fully deterministic comparison state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap_eom <= '0;
      r_tmo_hit <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cap_data[i] <= '0;
        r_beat[i]     <= '0;
        r_stall[i]    <= '0;
      end
    end else begin
      r_tmo_hit <= w_tmo_hit_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cap_ld[i]) begin
          r_cap_data[i] <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
          r_cap_eom[i]  <= ch_eom[i];
        end
        r_beat[i]  <= w_beat_nxt[i];
        r_stall[i] <= w_stall_nxt[i];
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < NUM_ERR; k++) begin
      w_pop = w_pop + POP_W'(w_viol[k]);
    end

    // Scan downward so the lowest channel, then lowest code, wins.
    w_first_ch   = '0;
    w_first_code = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      for (int c = 3; c >= 0; c--) begin
        if (w_viol[i*4 + c]) begin
          w_first_ch   = CH_W'(i);
          w_first_code = 2'(c);
        end
      end
    end

    w_cnt_base = clr ? '0 : r_cnt;
    w_sum      = SUM_W'(w_cnt_base) + SUM_W'(w_pop);
    w_cnt_nxt  = (w_sum > CNT_MAX) ? {ERR_CNT_WIDTH{1'b1}} : w_sum[ERR_CNT_WIDTH-1:0];
  end

  // clr clears first; violations seen in the same cycle are then applied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pulse      <= '0;
      r_sticky     <= '0;
      r_cnt        <= '0;
      r_first_vld  <= 1'b0;
      r_first_ch   <= '0;
      r_first_code <= '0;
    end else begin
      r_pulse  <= w_viol;
      r_sticky <= (clr ? '0 : r_sticky) | w_viol;
      r_cnt    <= w_cnt_nxt;
      if (clr) begin
        r_first_vld  <= 1'b0;
        r_first_ch   <= '0;
        r_first_code <= '0;
      end
      if ((clr || !r_first_vld) && (|w_viol)) begin
        r_first_vld  <= 1'b1;
        r_first_ch   <= w_first_ch;
        r_first_code <= w_first_code;
      end
    end
  end

  assign err_pulse  = r_pulse;
  assign err_sticky = r_sticky;
  assign err_any    = |r_sticky;
  assign err_cnt    = r_cnt;
  assign first_vld  = r_first_vld;
  assign first_ch   = r_first_ch;
  assign first_code = r_first_code;

endmodule

// File: tb/tb_uvma_mapu_b_proto_chkr.sv
// Self-checking bench for uvma_mapu_b_proto_chkr: directed scenarios plus random
// traffic compared against a transaction-level reference model.
module tb_uvma_mapu_b_proto_chkr;

  localparam int NUM_CH  = 2;
  localparam int DW      = 32;
  localparam int MB      = 9;
  localparam int TMO     = 256;
  localparam int CW      = 8;
  localparam int NE      = NUM_CH * 4;
  localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   enable;
  logic                   clr;
  logic [NUM_CH-1:0]      ch_vld;
  logic [NUM_CH-1:0]      ch_rdy;
  logic [NUM_CH-1:0]      ch_eom;
  logic [NUM_CH*DW-1:0]   ch_data;
  logic [NE-1:0]          err_pulse;
  logic [NE-1:0]          err_sticky;
  logic                   err_any;
  logic [CW-1:0]          err_cnt;
  logic                   first_vld;
  logic [CHW-1:0]         first_ch;
  logic [1:0]             first_code;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: channel "pending" flag with captured beat, beat position
  // within the matrix, and the length of the current stall run.
  bit              m_pend [NUM_CH];
  logic [DW-1:0]   m_cap_d[NUM_CH];
  bit              m_cap_e[NUM_CH];
  int              m_beat [NUM_CH];
  int              m_run  [NUM_CH];
  logic [NE-1:0]   e_pulse;
  logic [NE-1:0]   e_sticky;
  int              e_cnt;
  bit              e_fv;
  logic [CHW-1:0]  e_fch;
  logic [1:0]      e_fcode;

  uvma_mapu_b_proto_chkr #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .MATRIX_BEATS(MB),
    .TIMEOUT(TMO), .ERR_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clr(clr),
    .ch_vld(ch_vld), .ch_rdy(ch_rdy), .ch_eom(ch_eom), .ch_data(ch_data),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_any(err_any),
    .err_cnt(err_cnt), .first_vld(first_vld), .first_ch(first_ch),
    .first_code(first_code)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic reset_model();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pend[c] = 0; m_cap_d[c] = '0; m_cap_e[c] = 0; m_beat[c] = 0; m_run[c] = 0;
    end
    e_pulse = '0; e_sticky = '0; e_cnt = 0; e_fv = 0; e_fch = '0; e_fcode = '0;
  endtask

  // Applies the current inputs to the model, then advances one clock and
  // returns #1 after the edge, where DUT outputs should match e_*.
  task automatic step();
    logic [NE-1:0] viol;
    int idx;
    viol = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic v, r, e, last;
      logic [DW-1:0] d;
      v = ch_vld[c]; r = ch_rdy[c]; e = ch_eom[c]; d = ch_data[c*DW +: DW];
      if (enable) begin
        if (m_pend[c]) begin
          if (!v) viol[c*4 + 1] = 1'b1;
          else if (d !== m_cap_d[c] || e !== m_cap_e[c]) viol[c*4 + 0] = 1'b1;
        end
        if (v && r) begin
          last = (m_beat[c] == MB - 1);
          if (e != last) viol[c*4 + 2] = 1'b1;
          m_beat[c] = (e || last) ? 0 : m_beat[c] + 1;
        end
        if (m_run[c] == TMO) viol[c*4 + 3] = 1'b1;
        if (!m_pend[c] && v && !r) begin
          m_cap_d[c] = d; m_cap_e[c] = e;
        end
        m_pend[c] = v && !r;
        m_run[c]  = (v && !r) ? m_run[c] + 1 : 0;
      end else begin
        m_pend[c] = 0;
        m_run[c]  = 0;
      end
    end
    e_pulse = viol;
    if (clr) begin
      e_sticky = '0; e_cnt = 0; e_fv = 0; e_fch = '0; e_fcode = '0;
    end
    e_sticky = e_sticky | viol;
    e_cnt = e_cnt + $countones(viol);
    if (e_cnt > CNT_MAX) e_cnt = CNT_MAX;
    if (!e_fv && viol != '0) begin
      idx = 0;
      for (int k = NE - 1; k >= 0; k--) if (viol[k]) idx = k;
      e_fv = 1; e_fch = CHW'(idx / 4); e_fcode = 2'(idx % 4);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic idle_inputs();
    ch_vld = '0; ch_rdy = '0; ch_eom = '0;
  endtask

  // One beat on channel c with random ready; data and eom held while stalled.
  task automatic send_beat(input int c, input bit eom);
    bit hs;
    ch_vld[c] = 1'b1; ch_eom[c] = eom; ch_data[c*DW +: DW] = $urandom;
    hs = 0;
    for (int t = 0; t < 16 && !hs; t++) begin
      ch_rdy[c] = (t == 15) ? 1'b1 : 1'($urandom_range(0, 1));
      hs = ch_rdy[c];
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; clr = 1'b0; idle_inputs(); ch_data = '0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (err_pulse !== '0)  begin n_errors++; $display("FAIL reset err_pulse: got %h expected 0", err_pulse); end
    n_checks++; if (err_sticky !== '0) begin n_errors++; $display("FAIL reset err_sticky: got %h expected 0", err_sticky); end
    n_checks++; if (err_any !== 1'b0)  begin n_errors++; $display("FAIL reset err_any: got %b expected 0", err_any); end
    n_checks++; if (err_cnt !== '0)    begin n_errors++; $display("FAIL reset err_cnt: got %0d expected 0", err_cnt); end
    n_checks++; if (first_vld !== 1'b0) begin n_errors++; $display("FAIL reset first_vld: got %b expected 0", first_vld); end
    n_checks++; if (first_ch !== '0)   begin n_errors++; $display("FAIL reset first_ch: got %0d expected 0", first_ch); end
    n_checks++; if (first_code !== '0) begin n_errors++; $display("FAIL reset first_code: got %0d expected 0", first_code); end
    reset_n = 1'b1; enable = 1'b1;
    step();
  endtask

  task automatic test_clean_traffic();
    for (int b = 1; b <= 18; b++) begin
      send_beat(0, (b % 9) == 0);
      n_checks++; if (err_any !== 1'b0) begin n_errors++; $display("FAIL clean err_any beat %0d: got %b expected 0", b, err_any); end
      n_checks++; if (err_cnt !== '0)   begin n_errors++; $display("FAIL clean err_cnt beat %0d: got %0d expected 0", b, err_cnt); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_stab();
    do_clr();
    ch_vld[1] = 1'b1; ch_rdy[1] = 1'b0; ch_eom[1] = 1'b0; ch_data[DW +: DW] = 32'h1234;
    step();
    n_checks++; if (err_pulse !== '0) begin n_errors++; $display("FAIL stab pre-pulse: got %h expected 0", err_pulse); end
    ch_data[DW +: DW] = 32'h1235;
    step();
    n_checks++; if (err_pulse !== 8'h10) begin n_errors++; $display("FAIL stab err_pulse: got %h expected 10", err_pulse); end
    n_checks++; if (first_vld !== 1'b1) begin n_errors++; $display("FAIL stab first_vld: got %b expected 1", first_vld); end
    n_checks++; if (first_ch !== 1'b1) begin n_errors++; $display("FAIL stab first_ch: got %0d expected 1", first_ch); end
    n_checks++; if (first_code !== 2'd0) begin n_errors++; $display("FAIL stab first_code: got %0d expected 0", first_code); end
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL stab err_cnt: got %0d expected 1", err_cnt); end
    ch_data[DW +: DW] = 32'h1234; ch_rdy[1] = 1'b1;
    step();
    idle_inputs();
    step();
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL stab err_cnt after release: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_premature_eom();
    do_clr();
    for (int b = 1; b <= 5; b++) send_beat(0, b == 5);
    n_checks++; if (err_pulse !== 8'h04) begin n_errors++; $display("FAIL eom err_pulse: got %h expected 04", err_pulse); end
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL eom err_cnt: got %0d expected 1", err_cnt); end
    n_checks++; if (first_code !== 2'd2) begin n_errors++; $display("FAIL eom first_code: got %0d expected 2", first_code); end
    for (int b = 1; b <= 9; b++) send_beat(0, b == 9);
    idle_inputs();
    step();
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL eom recovered err_cnt: got %0d expected 1", err_cnt); end
    n_checks++; if (err_sticky !== e_sticky) begin n_errors++; $display("FAIL eom err_sticky: got %h expected %h", err_sticky, e_sticky); end
  endtask

  task automatic test_timeout();
    int n_tmo, at;
    do_clr();
    n_tmo = 0; at = -1;
    ch_vld[0] = 1'b1; ch_rdy[0] = 1'b0; ch_eom[0] = 1'b0; ch_data[0 +: DW] = 32'hcafe_f00d;
    for (int k = 0; k < 300; k++) begin
      step();
      if (err_pulse[3]) begin n_tmo++; at = k; end
    end
    n_checks++; if (n_tmo != 1) begin n_errors++; $display("FAIL timeout pulse count: got %0d expected 1", n_tmo); end
    n_checks++; if (at != 256) begin n_errors++; $display("FAIL timeout pulse cycle: got %0d expected 257 after vld (index 256)", at + 1); end
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL timeout err_cnt: got %0d expected 1", err_cnt); end
    ch_rdy[0] = 1'b1;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_simultaneous();
    do_clr();
    for (int r = 0; r < 200; r++) begin
      ch_vld = '1; ch_rdy = '0; ch_eom = '0; ch_data = {$urandom, $urandom};
      step();
      ch_vld = '0;
      step();
      if (r == 0) begin
        n_checks++; if (err_pulse !== 8'h22) begin n_errors++; $display("FAIL simul err_pulse: got %h expected 22", err_pulse); end
        n_checks++; if (err_cnt !== 8'd2) begin n_errors++; $display("FAIL simul err_cnt: got %0d expected 2", err_cnt); end
        n_checks++; if (first_ch !== 1'b0) begin n_errors++; $display("FAIL simul first_ch: got %0d expected 0", first_ch); end
        n_checks++; if (first_code !== 2'd1) begin n_errors++; $display("FAIL simul first_code: got %0d expected 1", first_code); end
      end
    end
    n_checks++; if (err_cnt !== 8'd255) begin n_errors++; $display("FAIL simul saturate err_cnt: got %0d expected 255", err_cnt); end
  endtask

  task automatic test_clr_collision();
    idle_inputs();
    ch_vld[1] = 1'b1; ch_data[DW +: DW] = 32'haaaa_0001;
    step();
    ch_data[DW +: DW] = 32'haaaa_0002; clr = 1'b1;
    step();
    clr = 1'b0;
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL clr+stab err_cnt: got %0d expected 1", err_cnt); end
    n_checks++; if (err_sticky !== 8'h10) begin n_errors++; $display("FAIL clr+stab err_sticky: got %h expected 10", err_sticky); end
    n_checks++; if (first_vld !== 1'b1 || first_ch !== 1'b1 || first_code !== 2'd0) begin
      n_errors++; $display("FAIL clr+stab first: got vld=%b ch=%0d code=%0d expected 1/1/0", first_vld, first_ch, first_code);
    end
    ch_data[DW +: DW] = 32'haaaa_0001; ch_rdy[1] = 1'b1;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    do_clr();
    for (int b = 1; b <= 4; b++) send_beat(0, 1'b0);
    ch_vld[0] = 1'b1; ch_rdy[0] = 1'b0; ch_data[0 +: DW] = 32'h0000_beef;
    step();
    ch_data[0 +: DW] = 32'h0000_bee0;
    step();
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL reset-mid pre err_cnt: got %0d expected 1", err_cnt); end
    reset_n = 1'b0;
    #2;
    n_checks++; if (err_pulse !== '0 || err_sticky !== '0 || err_any !== 1'b0) begin
      n_errors++; $display("FAIL reset-mid flags: got pulse=%h sticky=%h any=%b expected 0", err_pulse, err_sticky, err_any);
    end
    n_checks++; if (err_cnt !== '0 || first_vld !== 1'b0 || first_ch !== '0 || first_code !== '0) begin
      n_errors++; $display("FAIL reset-mid capture: got cnt=%0d fv=%b ch=%0d code=%0d expected 0", err_cnt, first_vld, first_ch, first_code);
    end
    reset_model();
    idle_inputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    for (int b = 1; b <= 9; b++) send_beat(0, b == 9);
    idle_inputs();
    step();
    n_checks++; if (err_cnt !== '0 || err_any !== 1'b0) begin
      n_errors++; $display("FAIL reset-mid beat restart: got cnt=%0d any=%b expected 0/0", err_cnt, err_any);
    end
  endtask

  task automatic test_enable();
    do_clr();
    for (int b = 1; b <= 3; b++) send_beat(0, 1'b0);
    ch_vld[0] = 1'b1; ch_rdy[0] = 1'b0; ch_data[0 +: DW] = 32'h5555_0000;
    step();
    enable = 1'b0; ch_data[0 +: DW] = 32'h5555_0001;
    step();
    ch_rdy[0] = 1'b1;
    repeat (4) step();
    ch_vld[0] = 1'b0;
    step();
    enable = 1'b1;
    step();
    n_checks++; if (err_cnt !== '0 || err_any !== 1'b0) begin
      n_errors++; $display("FAIL disable suppress: got cnt=%0d any=%b expected 0/0", err_cnt, err_any);
    end
    for (int b = 1; b <= 6; b++) send_beat(0, b == 6);
    idle_inputs();
    step();
    n_checks++; if (err_cnt !== '0) begin n_errors++; $display("FAIL disable beat hold err_cnt: got %0d expected 0", err_cnt); end
    ch_vld[0] = 1'b1; ch_data[0 +: DW] = 32'h7777_0000;
    step();
    ch_data[0 +: DW] = 32'h7777_0001;
    step();
    n_checks++; if (err_pulse !== 8'h01) begin n_errors++; $display("FAIL enable stab err_pulse: got %h expected 01", err_pulse); end
    enable = 1'b0;
    step();
    n_checks++; if (err_pulse !== '0 || err_cnt !== 8'd1 || first_vld !== 1'b1) begin
      n_errors++; $display("FAIL disable hold: got pulse=%h cnt=%0d fv=%b expected 00/1/1", err_pulse, err_cnt, first_vld);
    end
    idle_inputs(); enable = 1'b1;
    step();
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL re-enable err_cnt: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_vld[c] && !ch_rdy[c]) begin
          ch_vld[c] = ($urandom_range(0, 9) != 0);
          if ($urandom_range(0, 19) == 0) ch_data[c*DW +: DW] = ch_data[c*DW +: DW] ^ 32'h1;
          if ($urandom_range(0, 39) == 0) ch_eom[c] = ~ch_eom[c];
        end else begin
          ch_vld[c] = ($urandom_range(0, 2) != 0);
          ch_data[c*DW +: DW] = $urandom;
          ch_eom[c] = ($urandom_range(0, 5) == 0);
        end
        ch_rdy[c] = 1'($urandom_range(0, 1));
      end
      enable = ($urandom_range(0, 31) != 0);
      clr    = ($urandom_range(0, 49) == 0);
      step();
      n_checks++; if (err_pulse !== e_pulse) begin n_errors++; $display("FAIL rand err_pulse cyc %0d: got %h expected %h", cyc, err_pulse, e_pulse); end
      n_checks++; if (err_sticky !== e_sticky) begin n_errors++; $display("FAIL rand err_sticky cyc %0d: got %h expected %h", cyc, err_sticky, e_sticky); end
      n_checks++; if (err_any !== (e_sticky != '0)) begin n_errors++; $display("FAIL rand err_any cyc %0d: got %b expected %b", cyc, err_any, e_sticky != '0); end
      n_checks++; if (err_cnt !== CW'(e_cnt)) begin n_errors++; $display("FAIL rand err_cnt cyc %0d: got %0d expected %0d", cyc, err_cnt, e_cnt); end
      n_checks++; if (first_vld !== e_fv) begin n_errors++; $display("FAIL rand first_vld cyc %0d: got %b expected %b", cyc, first_vld, e_fv); end
      n_checks++; if (first_ch !== e_fch) begin n_errors++; $display("FAIL rand first_ch cyc %0d: got %0d expected %0d", cyc, first_ch, e_fch); end
      n_checks++; if (first_code !== e_fcode) begin n_errors++; $display("FAIL rand first_code cyc %0d: got %0d expected %0d", cyc, first_code, e_fcode); end
    end
    clr = 1'b0; enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_traffic();
    test_stab();
    test_premature_eom();
    test_timeout();
    test_simultaneous();
    test_clr_collision();
    test_reset_mid();
    test_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
